// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader that fills instruction memory and holds the core in reset until loaded
//   clk, reset (async active-low), start/word_count: begin a load of word_count words
//   byte_valid/byte_data/byte_ready: little-endian byte stream handshake
//   mem_we/mem_addr/mem_wdata: instruction memory write port (byte address, word aligned)
//   core_reset: datapath reset; busy: load in progress; done: last word written pulse; error: sticky bad start
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   word_count,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  state_t state, state_nx;
  logic [AW:0] count;
  logic [AW-1:0] word_idx;
  logic [1:0] byte_idx;
  logic [31:0] word;
  logic loaded, take, start_ok, last;
  assign start_ok = word_count != '0 && word_count <= DEPTH_W;
  assign take = byte_valid && state == RECV;
  assign last = {1'b0, word_idx} == count - 1'b1;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = (start && start_ok) ? RECV : IDLE;
      RECV:  state_nx = (take && byte_idx == 2'd3) ? WRITE : RECV;
      WRITE: state_nx = last ? DONE : RECV;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word     <= '0;
      loaded   <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        if (start_ok) begin
          count    <= word_count;
          word_idx <= '0;
          byte_idx <= '0;
          error    <= 1'b0;
        end else
          error <= 1'b1;
      end
      if (take) begin
        word[{byte_idx, 3'b000} +: 8] <= byte_data;
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == WRITE) word_idx <= word_idx + 1'b1;
      if (state == DONE) loaded <= 1'b1;
    end
  assign byte_ready = state == RECV;
  assign mem_we     = state == WRITE;
  assign mem_addr   = {{(30-AW){1'b0}}, word_idx, 2'b00};
  assign mem_wdata  = word;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign core_reset = !loaded || busy;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0, reset, start, byte_valid;
  logic [5:0] word_count;
  logic [7:0] byte_data;
  logic byte_ready, mem_we, core_reset, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;
  int total = 0, bad = 0;

  imem_loader #(.DEPTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic begin_load(input logic [5:0] n);
    word_count = n;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", byte_ready, 1);
  endtask

  task automatic load_word(input logic [31:0] w, input int stall);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        byte_valid = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick;
          chk("stall_ready", byte_ready, 1);
          chk("stall_no_we", mem_we, 0);
        end
      end
      byte_valid = 1'b1;
      byte_data = w[8*k +: 8];
      tick;
      if (k < 3) chk("recv_no_we", mem_we, 0);
    end
    byte_valid = 1'b0;
  endtask

  task automatic chk_write(input logic [31:0] addr, input logic [31:0] data);
    chk("we", mem_we, 1);
    chk("addr", mem_addr, addr);
    chk("wdata", mem_wdata, data);
    chk("we_not_ready", byte_ready, 0);
  endtask

  task automatic finish_load;
    tick;
    chk("done_pulse", done, 1);
    chk("done_core_reset", core_reset, 1);
    tick;
    chk("done_fall", done, 0);
    chk("idle_busy", busy, 0);
    chk("released", core_reset, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) tick;
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_core", core_reset, 1);
    reset = 1'b1;
    repeat (5) tick;
    chk("idle_core", core_reset, 1);
    chk("idle_busy0", busy, 0);
    chk("idle_ready", byte_ready, 0);
    chk("idle_we", mem_we, 0);

    begin_load(6'd2);
    load_word(32'h00500013, 0);
    chk_write(32'h0, 32'h00500013);
    tick;
    load_word(32'h00100293, 0);
    chk_write(32'h4, 32'h00100293);
    finish_load;

    begin_load(6'd2);
    load_word(32'h00500013, 3);
    chk_write(32'h0, 32'h00500013);
    tick;
    load_word(32'h00100293, 3);
    chk_write(32'h4, 32'h00100293);
    finish_load;

    word_count = 6'd0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("err0", error, 1);
    chk("err0_busy", busy, 0);
    chk("err0_we", mem_we, 0);
    chk("err0_core", core_reset, 0);
    word_count = 6'd33; start = 1'b1;
    tick;
    start = 1'b0;
    chk("err33", error, 1);
    chk("err33_ready", byte_ready, 0);
    tick;
    chk("err33_we", mem_we, 0);
    chk("err_sticky", error, 1);
    begin_load(6'd1);
    chk("err_clear", error, 0);
    word_count = 6'd0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_start_ignored", error, 0);
    load_word(32'hDEADBEEF, 0);
    chk_write(32'h0, 32'hDEADBEEF);
    finish_load;

    begin_load(6'd32);
    for (int i = 0; i < 32; i++) begin
      load_word({8'h5C, ~8'(i), 8'hA5, 8'(i)}, 0);
      chk_write(32'(i) * 4, {8'h5C, ~8'(i), 8'hA5, 8'(i)});
      if (i < 31) begin
        tick;
        chk("full_no_done", done, 0);
      end
    end
    chk("last_addr", mem_addr, 32'h7C);
    finish_load;

    begin_load(6'd4);
    load_word(32'h11223344, 0);
    chk_write(32'h0, 32'h11223344);
    tick;
    byte_valid = 1'b1; byte_data = 8'hAA;
    tick;
    byte_data = 8'hBB;
    tick;
    #2 reset = 1'b0;
    #1;
    byte_valid = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_ready", byte_ready, 0);
    chk("mid_we", mem_we, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_wdata", mem_wdata, 0);
    chk("mid_core", core_reset, 1);
    tick;
    reset = 1'b1;
    tick;
    chk("post_rst_core", core_reset, 1);
    begin_load(6'd1);
    load_word(32'h0000006F, 0);
    chk_write(32'h0, 32'h0000006F);
    finish_load;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
